// File: rtl/sliding_window_sequence_generator_pkg.sv
// Constants shared by the serial frame generator and its sliding-window detector partner.
package sliding_window_sequence_generator_pkg;

  localparam int SYNC_W = 8;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 8'b1100_1001;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

endpackage

// File: rtl/sliding_window_sequence_generator_if.sv
// Payload handshake and serial output bundle of the sequence generator.
interface sliding_window_sequence_generator_if #(
  parameter int DATA_W = sliding_window_sequence_generator_pkg::DATA_W
);

  // Handshake: the source raises in_valid with in_data and holds both until a
  // posedge where in_valid && in_ready; that edge transfers the word. in_ready
  // depends only on registered generator state, never on in_valid.
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              busy;
  logic              frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, ser_valid, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, ser_valid, busy, frame_done
  );

endinterface

// File: rtl/seq_gen_shifter.sv
// Loadable MSB-first shift register with a down-counter flagging its last bit.
module seq_gen_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         msb,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;

  // Load wins over shift so a word accepted on the final bit restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= CW'(W - 1);
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  assign msb  = sr[W-1];
  assign last = (cnt == '0);

endmodule

// File: rtl/sliding_window_sequence_generator.sv
// Serialises payload words as SYNC_PATTERN + payload frames; define SEQ_GEN_PARITY_EN to append an even-parity bit.
module sliding_window_sequence_generator
  import sliding_window_sequence_generator_pkg::*;
#(
  parameter int                SYNC_W       = sliding_window_sequence_generator_pkg::SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = sliding_window_sequence_generator_pkg::SYNC_PATTERN,
  parameter int                DATA_W       = sliding_window_sequence_generator_pkg::DATA_W
) (
  input  logic                                clk,
  input  logic                                rst,
  sliding_window_sequence_generator_if.slave  bus,
  output state_t                              dbg_state
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   final_bit;
  logic   sync_msb;
  logic   sync_last;
  logic   data_msb;
  logic   data_last;

  assign accept = bus.in_valid && bus.in_ready;

  seq_gen_shifter #(.W(SYNC_W)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (state == SYNC),
    .load_data (SYNC_PATTERN),
    .msb       (sync_msb),
    .last      (sync_last)
  );

  seq_gen_shifter #(.W(DATA_W)) u_data (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (state == DATA),
    .load_data (bus.in_data),
    .msb       (data_msb),
    .last      (data_last)
  );

`ifdef SEQ_GEN_PARITY_EN
  logic parity_bit;

  // Parity is taken from the word as accepted, since data_sr is consumed by shifting.
  always_ff @(posedge clk) begin
    if (rst)         parity_bit <= 1'b0;
    else if (accept) parity_bit <= ^bus.in_data;
  end

  assign final_bit = (state == PARITY);
`else
  assign final_bit = (state == DATA) && data_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SYNC;
      SYNC: if (sync_last) state_nxt = DATA;
      DATA: begin
        if (data_last) begin
`ifdef SEQ_GEN_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = accept ? SYNC : IDLE;
`endif
        end
      end
      PARITY: begin
`ifdef SEQ_GEN_PARITY_EN
        state_nxt = accept ? SYNC : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final bit opens the ready window so the next frame follows with no gap.
  always_comb begin
    bus.in_ready   = (state == IDLE) || final_bit;
    bus.ser_valid  = (state != IDLE);
    bus.busy       = (state != IDLE);
    bus.frame_done = final_bit;
    bus.ser_out    = 1'b0;
    case (state)
      SYNC: bus.ser_out = sync_msb;
      DATA: bus.ser_out = data_msb;
      PARITY: begin
`ifdef SEQ_GEN_PARITY_EN
        bus.ser_out = parity_bit;
`endif
      end
      default: bus.ser_out = 1'b0;
    endcase
  end

  assign dbg_state = state;

endmodule
